// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : shared FSM state type and forward-select codes for the hazard unit
// Rev 1.0
// ============================================================================
package pipe_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipeState_t;

  localparam int FWD_REG   = 0;
  localparam int FWD_EXMEM = 1;
  localparam int FWD_MEMWB = 2;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
`default_nettype none
// ============================================================================
// fwd_select : picks the youngest writing stage whose destination matches src
// Rev 1.0
// ============================================================================
module fwd_select
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_STAGES = 2,
  parameter int FSEL_W     = $clog2(FWD_STAGES + 1)
) (
  input  logic [REG_ADDR_W-1:0]            srcReg,
  input  logic [FWD_STAGES*REG_ADDR_W-1:0] fwdRd,
  input  logic [FWD_STAGES-1:0]            fwdWe,
  output logic [FSEL_W-1:0]                sel
);

  logic [FWD_STAGES-1:0] w_match;

  genvar gK;
  generate
    for (gK = 0; gK < FWD_STAGES; gK++) begin : g_match
      assign w_match[gK] = fwdWe[gK]
                         && (fwdRd[gK*REG_ADDR_W +: REG_ADDR_W] != '0)
                         && (fwdRd[gK*REG_ADDR_W +: REG_ADDR_W] == srcReg);
    end
  endgenerate

  // Walk from the oldest stage down so the youngest match wins.
  always_comb begin
    sel = FSEL_W'(FWD_REG);
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (w_match[k]) sel = FSEL_W'(k + 1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : stall / flush / forward control for the integer pipeline
// Optional stall performance counter enabled by macro PIPE_PERF_CNT_EN.
// Rev 1.0
// ============================================================================
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int FWD_STAGES  = 2,
  parameter int MEM_TIMEOUT = 255,
  localparam int FSEL_W     = $clog2(FWD_STAGES + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REG_ADDR_W-1:0]            id_rs,
  input  logic [REG_ADDR_W-1:0]            id_rt,
  input  logic                             id_uses_rs,
  input  logic                             id_uses_rt,
  input  logic                             id_jump,
  input  logic                             id_branch,
  input  logic                             id_taken,
  input  logic [REG_ADDR_W-1:0]            ex_rs,
  input  logic [REG_ADDR_W-1:0]            ex_rt,
  input  logic [REG_ADDR_W-1:0]            ex_rd,
  input  logic                             ex_reg_write,
  input  logic                             ex_mem_read,
  input  logic [FWD_STAGES*REG_ADDR_W-1:0] fwd_rd,
  input  logic [FWD_STAGES-1:0]            fwd_we,
  input  logic                             dmem_req,
  input  logic                             dmem_ready,
  output logic                             pc_ld,
  output logic                             if_id_write,
  output logic                             if_id_flush,
  output logic                             id_ex_bubble,
  output logic                             pipe_en,
  output logic [FSEL_W-1:0]                fwd_a,
  output logic [FSEL_W-1:0]                fwd_b,
  output logic                             mem_timeout,
  output logic [31:0]                      stall_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  pipeState_t        r_state;
  logic [WAIT_W-1:0] r_waitCnt;
  logic              r_memTimeout;

  logic              w_frozen;
  logic              w_loadUse;
  logic              w_branchHaz;
  logic              w_redirect;
  logic [WAIT_W-1:0] w_waitNext;

  assign w_frozen    = dmem_req && !dmem_ready;
  assign w_loadUse   = ex_mem_read && (ex_rd != '0)
                     && ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  assign w_branchHaz = id_branch && ex_reg_write && (ex_rd != '0)
                     && ((ex_rd == id_rs) || (ex_rd == id_rt));
  assign w_redirect  = id_jump || (id_branch && id_taken);
  assign w_waitNext  = (r_waitCnt == '1) ? r_waitCnt : r_waitCnt + WAIT_W'(1);

  // Freeze outranks hazards, hazards outrank redirects.
  always_comb begin
    pc_ld        = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_en      = 1'b1;
    if (w_frozen) begin
      pc_ld       = 1'b0;
      if_id_write = 1'b0;
      pipe_en     = 1'b0;
    end else if (w_loadUse || w_branchHaz) begin
      pc_ld        = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (w_redirect) begin
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= RUN;
      r_waitCnt    <= '0;
      r_memTimeout <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_frozen) begin
            r_state   <= MEM_WAIT;
            r_waitCnt <= '0;
          end
        end
        MEM_WAIT: begin
          r_waitCnt <= w_waitNext;
          if (32'(w_waitNext) >= 32'(MEM_TIMEOUT)) r_memTimeout <= 1'b1;
          if (dmem_ready) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign mem_timeout = r_memTimeout;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stallCnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stallCnt <= '0;
    end else if (!pc_ld && (r_stallCnt != 32'hFFFF_FFFF)) begin
      r_stallCnt <= r_stallCnt + 32'd1;
    end
  end

  assign stall_cnt = r_stallCnt;
`else
  assign stall_cnt = '0;
`endif

  fwd_select #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_STAGES (FWD_STAGES),
    .FSEL_W     (FSEL_W)
  ) u_fwdA (
    .srcReg (ex_rs),
    .fwdRd  (fwd_rd),
    .fwdWe  (fwd_we),
    .sel    (fwd_a)
  );

  fwd_select #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_STAGES (FWD_STAGES),
    .FSEL_W     (FSEL_W)
  ) u_fwdB (
    .srcReg (ex_rt),
    .fwdRd  (fwd_rd),
    .fwdWe  (fwd_we),
    .sel    (fwd_b)
  );

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5: register-index width.
REQ-002 SHALL have parameter FWD_STAGES, default 2, legal 1..4: number of later stages that can forward into EX (index 0 = EX/MEM, 1 = MEM/WB, ...).
REQ-003 SHALL have parameter MEM_TIMEOUT, default 255: maximum data-memory wait cycles before an error is flagged.
REQ-004 SHALL use FSEL_W = $clog2(FWD_STAGES+1) as the forward-select width.
REQ-005 Ports, in this order: clk in 1, rising-edge clock; rst in 1, one clock, reset synchronous and active-low.
REQ-006 Decode-stage ports: id_rs in REG_ADDR_W, ID source 1; id_rt in REG_ADDR_W, ID source 2; id_uses_rs in 1; id_uses_rt in 1; id_jump in 1; id_branch in 1, beq/bne in ID; id_taken in 1, branch condition true.
REQ-007 Execute and forwarding ports: ex_rs in REG_ADDR_W; ex_rt in REG_ADDR_W; ex_rd in REG_ADDR_W; ex_reg_write in 1; ex_mem_read in 1; fwd_rd in FWD_STAGES*REG_ADDR_W, packed destination per stage; fwd_we in FWD_STAGES, regWrite per stage.
REQ-008 Memory handshake ports: dmem_req in 1, MEM stage access; dmem_ready in 1, access completes this cycle.
REQ-009 Control outputs: pc_ld out 1; if_id_write out 1; if_id_flush out 1; id_ex_bubble out 1, zeroes ID/EX control; pipe_en out 1, enables ID/EX, EX/MEM and MEM/WB.
REQ-010 Status outputs: fwd_a out FSEL_W; fwd_b out FSEL_W; mem_timeout out 1, sticky error; stall_cnt out 32, performance count.

Function
REQ-011 SHALL implement an FSM with states RUN and MEM_WAIT.
REQ-012 RUN→MEM_WAIT when dmem_req=1 and dmem_ready=0; MEM_WAIT→RUN on the cycle dmem_ready=1.
REQ-013 A request with dmem_ready=1 in the same cycle SHALL cause no stall.
REQ-014 Memory freeze: while dmem_req=1 and dmem_ready=0, in either state, pc_ld, if_id_write and pipe_en SHALL be 0, and if_id_flush and id_ex_bubble SHALL be 0; this condition has the highest priority.
REQ-015 Load-use hazard SHALL be raised when ex_mem_read=1, ex_rd!=0 and (id_uses_rs and id_rs==ex_rd, or id_uses_rt and id_rt==ex_rd).
REQ-016 Branch hazard SHALL be raised when id_branch=1, ex_reg_write=1, ex_rd!=0 and ex_rd matches id_rs or id_rt.
REQ-017 On either hazard, when not frozen: pc_ld=0, if_id_write=0, id_ex_bubble=1, pipe_en=1, if_id_flush=0, all for exactly that cycle.
REQ-018 Redirect, when not frozen and no hazard: id_jump=1, or id_branch=1 and id_taken=1, SHALL give if_id_flush=1 with pc_ld=1 for one cycle.
REQ-019 Hazard SHALL take priority over redirect; the redirect is re-evaluated on the following cycle.
REQ-020 Otherwise: pc_ld=if_id_write=pipe_en=1, if_id_flush=id_ex_bubble=0.
REQ-021 fwd_a SHALL be k+1 for the smallest k with fwd_we[k]=1, fwd_rd[k]!=0 and fwd_rd[k]==ex_rs, else 0; fwd_b is the same with ex_rt.
REQ-022 fwd_a and fwd_b SHALL be combinational, with zero latency.
REQ-023 A wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle, saturating.
REQ-024 When the wait count reaches MEM_TIMEOUT, mem_timeout SHALL be set and hold until reset; the FSM SHALL keep waiting.
REQ-025 stall_cnt SHALL increment by 1 each cycle in which pc_ld=0, saturating at 2^32-1.

Reset
REQ-026 On rst=0 at a rising edge: state=RUN, wait counter=0, mem_timeout=0, stall_cnt=0.
REQ-027 Reset mid-MEM_WAIT SHALL abandon the wait immediately.
REQ-028 Combinational outputs SHALL follow their inputs during reset; only registered state is cleared.

Configuration
REQ-029 SHALL use macro PIPE_PERF_CNT_EN: when defined, the stall_cnt counter is built; when undefined, stall_cnt is tied to 0 and no counter flops exist.
REQ-030 All other behaviour SHALL be identical with or without PIPE_PERF_CNT_EN.

Structure
REQ-031 Package pipe_pkg SHALL hold the FSM state enum (RUN, MEM_WAIT) and forward-select constants (FWD_REG=0, FWD_EXMEM=1, FWD_MEMWB=2).
REQ-032 SHALL contain one sub-module fwd_select, instantiated twice (operand A and operand B), computing the priority match of REQ-021.

Verification
REQ-033 ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 -> one cycle pc_ld=0, if_id_write=0, id_ex_bubble=1; stall_cnt increments by 1.
REQ-034 fwd_we=2'b11, fwd_rd={5'd3,5'd3}, ex_rs=3 -> fwd_a=1; with fwd_rd[0]=0 -> fwd_a=2; ex_rs=0 -> fwd_a=0.
REQ-035 id_branch=1, id_taken=1 together with a load-use hazard -> bubble first, if_id_flush=0; next cycle if_id_flush=1.
REQ-036 dmem_req=1 held, dmem_ready=0 for 3 cycles -> pipe_en=0 for 3 cycles, resume on the ready cycle; stall_cnt=3.
REQ-037 MEM_TIMEOUT=4, ready withheld 6 cycles -> mem_timeout=1 after wait count 4, stays 1 after ready; rst=0 clears it.
REQ-038 PIPE_PERF_CNT_EN undefined, scenario of REQ-036 -> stall_cnt stays 0, control outputs unchanged.
